// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default width shared by the serial adder files
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from two half adders and an OR
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;
  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit sum and carry of two inputs
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder slice plus a carry flop
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, acc_sr, acc_d;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_c, accept, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(fa_s), .cout(fa_c));
  // start is only honoured outside ADD, which covers both IDLE and the back-to-back DONE case
  assign accept = start && state != ST_ADD;
  assign last   = cnt == CW'(WIDTH - 1);
  assign acc_d  = {fa_s, acc_sr[WIDTH-1:1]};
  assign busy   = state == ST_ADD;
  assign done   = state == ST_DONE;
  always_comb begin
    state_d = ST_IDLE;
    state_d = accept ? ST_ADD : (state == ST_ADD) ? (last ? ST_DONE : ST_ADD) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_ADD) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      acc_sr <= acc_d;
      carry  <= fa_c;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= acc_d;
        cout <= fa_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors and sequences for the 8-bit adder, exhaustive sweep at WIDTH=4
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [7:0] sum;
  logic start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, cout4;
  logic [3:0] sum4;
  int n_cmp = 0, n_bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the cycle after an accept edge (or later, with fewer ticks expected)
  task automatic wait_done(input string name, input int exp_ticks, input logic [7:0] es, input logic ec);
    int k = 0, nbusy = 0;
    logic [7:0] held = sum;
    logic moved = 1'b0;
    while (!done && k < 20) begin
      if (busy) nbusy++;
      if (sum !== held) moved = 1'b1;
      tick();
      k++;
    end
    chk({name, " latency"}, k, exp_ticks);
    chk({name, " busy cycles"}, nbusy, exp_ticks);
    chk({name, " sum held during add"}, moved, 0);
    chk({name, " done"}, done, 1);
    chk({name, " busy in done"}, busy, 0);
    chk({name, " sum"}, sum, es);
    chk({name, " cout"}, cout, ec);
  endtask

  initial begin
    vec_t vecs[4];
    int k;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0};

    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done($sformatf("vec%0d", i), 8, vecs[i].s, vecs[i].c);
      tick();
      chk($sformatf("vec%0d done one cycle", i), done, 0);
      chk($sformatf("vec%0d sum hold", i), sum, vecs[i].s);
    end

    start_op(8'hA5, 8'h11, 1'b0);
    tick();
    tick();
    a = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored start", 5, 8'hB6, 1'b0);
    tick();
    chk("ignored start no reaccept", busy, 0);

    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'h99;
    wait_done("b2b first", 8, 8'h03, 1'b0);
    a = 8'h80; b = 8'h80; cin = 1'b0;
    tick();
    start = 1'b0;
    chk("b2b no idle gap", busy, 1);
    wait_done("b2b second", 8, 8'h00, 1'b1);

    tick();
    start_op(8'h12, 8'h34, 1'b0);
    wait_done("pre-reset op", 8, 8'h46, 1'b0);
    start_op(8'h22, 8'h33, 1'b1);
    tick();
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst sum", sum, 0);
    chk("async rst cout", cout, 0);
    chk("async rst done", done, 0);
    #2 rst = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) k++;
    end
    chk("no done after abort", k, 0);
    start_op(8'h22, 8'h33, 1'b1);
    wait_done("after reset", 8, 8'h56, 1'b0);
    tick();

    for (int va = 0; va < 16; va++)
      for (int vb = 0; vb < 16; vb++)
        for (int vc = 0; vc < 2; vc++) begin
          a4 = 4'(va); b4 = 4'(vb); cin4 = 1'(vc); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          k = 0;
          while (!done4 && k < 10) begin
            tick();
            k++;
          end
          chk($sformatf("w4 %0d+%0d+%0d", va, vb, vc), {27'd0, cout4, sum4}, va + vb + vc);
        end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
